cdb_arbiter_rr: RTL and testbench

Parametrised N-channel Common Data Bus arbiter for the OoO core. It replaces fixed 3-source priority with selectable round-robin or fixed priority, plus starvation aging. Requesters use a valid/ack handshake and the broadcast output is registered. It sits between the FU wrappers (ALU, FPU, LSU, MDU, …) and the RS/ROB/RAT snoop ports, and honours a pipeline flush.

---
 rtl/cdb_arbiter_rr.sv | 210 +++++++++++++++++++++
 tb/tb_cdb_arbiter_rr.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_rr
// Common Data Bus arbiter for the out-of-order core. NUM_CH functional-unit
// channels compete for a single registered broadcast slot on the CDB. The
// winner is chosen by round-robin (RR_MODE=1) or by fixed lowest-index
// priority (RR_MODE=0). A per-channel aging counter forces a grant to any
// channel that has waited MAX_WAIT cycles, which bounds the wait time in fixed
// mode. A pipeline flush suppresses the grant and clears all aging state.
//
// Ports
//   clk                 core clock, all state updates on the rising edge
//   rst_n               asynchronous active-low reset
//   flush_i             pipeline flush, no grant this cycle
//   req_valid_i         per-channel result valid, held until acked
//   req_result_i        flattened results, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_tag_i           flattened ROB tags
//   req_dest_reg_i      flattened architectural destination registers (5 bits each)
//   req_is_float_i      per-channel FP destination flag
//   req_ack_o           one-hot grant, combinational, same cycle as the request
//   cdb_valid_o         registered broadcast valid
//   cdb_value_o         registered result
//   cdb_tag_o           registered ROB tag
//   cdb_dest_reg_o      registered destination register
//   cdb_is_float_o      registered FP flag
//   cdb_source_fu_o     registered winner index+1, 0 when idle
// -----------------------------------------------------------------------------
module cdb_arbiter_rr #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 3,
  parameter int ID_WIDTH   = 3,
  parameter int RR_MODE    = 1,
  parameter int MAX_WAIT   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic [NUM_CH-1:0]          req_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_result_i,
  input  logic [NUM_CH*TAG_WIDTH-1:0]  req_tag_i,
  input  logic [NUM_CH*5-1:0]        req_dest_reg_i,
  input  logic [NUM_CH-1:0]          req_is_float_i,
  output logic [NUM_CH-1:0]          req_ack_o,
  output logic                       cdb_valid_o,
  output logic [DATA_WIDTH-1:0]      cdb_value_o,
  output logic [TAG_WIDTH-1:0]       cdb_tag_o,
  output logic [4:0]                 cdb_dest_reg_o,
  output logic                       cdb_is_float_o,
  output logic [ID_WIDTH-1:0]        cdb_source_fu_o
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_WAIT);
  localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

  // Channel index reached by stepping 'off' places up from 'base', wrapping
  // past the last channel back to channel 0.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_CH) begin
      sum = sum - NUM_CH;
    end else begin
      sum = sum;
    end
    return PTR_W'(sum);
  endfunction

  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0][CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic                  cdb_valid_q, cdb_valid_d;
  logic [DATA_WIDTH-1:0] cdb_value_q, cdb_value_d;
  logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
  logic [4:0]            cdb_dest_q, cdb_dest_d;
  logic                  cdb_float_q, cdb_float_d;
  logic [ID_WIDTH-1:0]   cdb_src_q, cdb_src_d;

  logic              aged_any_s, fix_any_s, rr_any_s, grant_any_s;
  logic [PTR_W-1:0]  aged_idx_s, fix_idx_s, rr_idx_s, grant_idx_s;
  logic [NUM_CH-1:0] req_ack_s;

  // Candidate winners for each policy and the final grant selection.
  always_comb begin
    aged_any_s  = 1'b0;
    aged_idx_s  = '0;
    fix_any_s   = 1'b0;
    fix_idx_s   = '0;
    rr_any_s    = 1'b0;
    rr_idx_s    = '0;
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    // Descending scans so the lowest index / smallest offset is the last
    // assignment and therefore wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_valid_i[i] && (MAX_WAIT > 0) && (wait_cnt_q[i] == WAIT_SAT)) begin
        aged_any_s = 1'b1;
        aged_idx_s = PTR_W'(i);
      end else begin
        aged_any_s = aged_any_s;
      end
      if (req_valid_i[i]) begin
        fix_any_s = 1'b1;
        fix_idx_s = PTR_W'(i);
      end else begin
        fix_any_s = fix_any_s;
      end
    end
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      if (req_valid_i[wrap_idx(rr_ptr_q, off)]) begin
        rr_any_s = 1'b1;
        rr_idx_s = wrap_idx(rr_ptr_q, off);
      end else begin
        rr_any_s = rr_any_s;
      end
    end
    if (flush_i) begin
      grant_any_s = 1'b0;
    end else if (aged_any_s) begin
      grant_any_s = 1'b1;
      grant_idx_s = aged_idx_s;
    end else if (RR_MODE != 0) begin
      grant_any_s = rr_any_s;
      grant_idx_s = rr_idx_s;
    end else begin
      grant_any_s = fix_any_s;
      grant_idx_s = fix_idx_s;
    end
    if (grant_any_s) begin
      req_ack_s = ONE_HOT0 << grant_idx_s;
    end else begin
      req_ack_s = '0;
    end
  end

  // The ack is masked by reset directly so no grant is visible while in reset.
  assign req_ack_o = req_ack_s & {NUM_CH{rst_n}};

  // Next broadcast contents and round-robin pointer advance.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_value_d = '0;
    cdb_tag_d   = '0;
    cdb_dest_d  = 5'd0;
    cdb_float_d = 1'b0;
    cdb_src_d   = '0;
    if (grant_any_s) begin
      rr_ptr_d    = (grant_idx_s == LAST_CH) ? '0 : grant_idx_s + PTR_W'(1);
      cdb_valid_d = 1'b1;
      cdb_value_d = req_result_i[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
      cdb_tag_d   = req_tag_i[int'(grant_idx_s)*TAG_WIDTH +: TAG_WIDTH];
      cdb_dest_d  = req_dest_reg_i[int'(grant_idx_s)*5 +: 5];
      cdb_float_d = req_is_float_i[grant_idx_s];
      cdb_src_d   = ID_WIDTH'(grant_idx_s) + ID_WIDTH'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Aging counters: count while requesting and losing, otherwise restart.
  always_comb begin
    wait_cnt_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_valid_i[i] && !req_ack_s[i] && !flush_i) begin
        if (wait_cnt_q[i] == WAIT_SAT) begin
          wait_cnt_d[i] = WAIT_SAT;
        end else begin
          wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
        end
      end else begin
        wait_cnt_d[i] = '0;
      end
    end
  end

  // State and broadcast registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      wait_cnt_q  <= '0;
      cdb_valid_q <= 1'b0;
      cdb_value_q <= '0;
      cdb_tag_q   <= '0;
      cdb_dest_q  <= 5'd0;
      cdb_float_q <= 1'b0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_value_q <= cdb_value_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_dest_q  <= cdb_dest_d;
      cdb_float_q <= cdb_float_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid_o     = cdb_valid_q;
  assign cdb_value_o     = cdb_value_q;
  assign cdb_tag_o       = cdb_tag_q;
  assign cdb_dest_reg_o  = cdb_dest_q;
  assign cdb_is_float_o  = cdb_float_q;
  assign cdb_source_fu_o = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter_rr
// Directed bench for cdb_arbiter_rr. Two instances share all inputs:
//   u_rr : round-robin, MAX_WAIT=8
//   u_fx : fixed priority, MAX_WAIT=3
// Each cycle the expected one-hot ack of both instances is given by hand; the
// broadcast on the following cycle is derived from that ack and a payload table.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter_rr;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int TW = 3;
  localparam int IW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              flush;
  logic [NC-1:0]     req_valid;
  logic [NC*DW-1:0]  req_result;
  logic [NC*TW-1:0]  req_tag;
  logic [NC*5-1:0]   req_dest;
  logic [NC-1:0]     req_float;

  logic [NC-1:0] ack_rr, ack_fx;
  logic          v_rr, v_fx, fl_rr, fl_fx;
  logic [DW-1:0] val_rr, val_fx;
  logic [TW-1:0] tag_rr, tag_fx;
  logic [4:0]    dst_rr, dst_fx;
  logic [IW-1:0] src_rr, src_fx;

  logic [DW-1:0] res_tab [NC] = '{32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0102, 32'h0000_0103};
  logic [TW-1:0] tag_tab [NC] = '{3'd0, 3'd5, 3'd2, 3'd3};
  logic [4:0]    dst_tab [NC] = '{5'd10, 5'd12, 5'd20, 5'd21};
  logic          flt_tab [NC] = '{1'b0, 1'b1, 1'b0, 1'b0};

  int n_vec = 0;
  int n_err = 0;

  cdb_arbiter_rr #(.NUM_CH(NC), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .ID_WIDTH(IW),
                   .RR_MODE(1), .MAX_WAIT(8)) u_rr (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_result_i(req_result), .req_tag_i(req_tag),
    .req_dest_reg_i(req_dest), .req_is_float_i(req_float),
    .req_ack_o(ack_rr), .cdb_valid_o(v_rr), .cdb_value_o(val_rr),
    .cdb_tag_o(tag_rr), .cdb_dest_reg_o(dst_rr), .cdb_is_float_o(fl_rr),
    .cdb_source_fu_o(src_rr)
  );

  cdb_arbiter_rr #(.NUM_CH(NC), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .ID_WIDTH(IW),
                   .RR_MODE(0), .MAX_WAIT(3)) u_fx (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_result_i(req_result), .req_tag_i(req_tag),
    .req_dest_reg_i(req_dest), .req_is_float_i(req_float),
    .req_ack_o(ack_fx), .cdb_valid_o(v_fx), .cdb_value_o(val_fx),
    .cdb_tag_o(tag_fx), .cdb_dest_reg_o(dst_fx), .cdb_is_float_o(fl_fx),
    .cdb_source_fu_o(src_fx)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source ID (index+1) implied by a one-hot grant, 0 for no grant.
  function automatic int src_of(input logic [NC-1:0] oh);
    for (int i = 0; i < NC; i++) begin
      if (oh[i]) return i + 1;
    end
    return 0;
  endfunction

  // One arbitration cycle: drive, check acks, then check the broadcast.
  task automatic cyc(input string tag, input logic [NC-1:0] v, input logic fl,
                     input logic [NC-1:0] e_rr, input logic [NC-1:0] e_fx);
    int s_rr;
    int s_fx;
    @(negedge clk);
    req_valid = v;
    flush     = fl;
    #1;
    check_eq({tag, ".ack_rr"}, 64'(ack_rr), 64'(e_rr));
    check_eq({tag, ".ack_fx"}, 64'(ack_fx), 64'(e_fx));
    s_rr = src_of(e_rr);
    s_fx = src_of(e_fx);
    @(posedge clk);
    #1;
    check_eq({tag, ".valid_rr"}, 64'(v_rr), 64'(s_rr != 0));
    check_eq({tag, ".src_rr"}, 64'(src_rr), 64'(s_rr));
    check_eq({tag, ".value_rr"}, 64'(val_rr), (s_rr != 0) ? 64'(res_tab[s_rr-1]) : 64'd0);
    check_eq({tag, ".valid_fx"}, 64'(v_fx), 64'(s_fx != 0));
    check_eq({tag, ".src_fx"}, 64'(src_fx), 64'(s_fx));
  endtask

  // Reset pulse that releases 2 time units after a rising edge.
  task automatic do_reset();
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    flush     = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  logic [NC-1:0] rr_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [NC-1:0] fx_seq [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010,
                                4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [NC-1:0] ag_rr [5]  = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
  logic [NC-1:0] ag_fx [5]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0001};

  initial begin
    for (int i = 0; i < NC; i++) begin
      req_result[i*DW +: DW] = res_tab[i];
      req_tag[i*TW +: TW]    = tag_tab[i];
      req_dest[i*5 +: 5]     = dst_tab[i];
      req_float[i]           = flt_tab[i];
    end
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 4'b1111;

    // Reset with every channel requesting.
    #12;
    check_eq("rst.ack_rr", 64'(ack_rr), 64'd0);
    check_eq("rst.ack_fx", 64'(ack_fx), 64'd0);
    check_eq("rst.valid_rr", 64'(v_rr), 64'd0);
    check_eq("rst.src_rr", 64'(src_rr), 64'd0);
    check_eq("rst.value_rr", 64'(val_rr), 64'd0);
    @(posedge clk);
    #1;
    check_eq("rst.edge_valid_rr", 64'(v_rr), 64'd0);
    check_eq("rst.edge_ack_fx", 64'(ack_fx), 64'd0);
    #1;
    rst_n = 1'b1;

    // All four channels continuously valid.
    for (int k = 0; k < 8; k++) begin
      cyc($sformatf("all%0d", k), 4'b1111, 1'b0, rr_seq[k], fx_seq[k]);
    end

    // Channels 0 and 2 only: aging forces channel 2 through in fixed mode.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc($sformatf("age%0d", k), 4'b0101, 1'b0, ag_rr[k], ag_fx[k]);
    end

    // Payload path through channel 1.
    do_reset();
    cyc("pay", 4'b0010, 1'b0, 4'b0010, 4'b0010);
    check_eq("pay.tag", 64'(tag_rr), 64'd5);
    check_eq("pay.dest", 64'(dst_rr), 64'd12);
    check_eq("pay.float", 64'(fl_rr), 64'd1);
    check_eq("pay.value_fx", 64'(val_fx), 64'hDEAD_BEEF);
    cyc("pay_idle", 4'b0000, 1'b0, 4'b0000, 4'b0000);
    check_eq("pay_idle.tag", 64'(tag_rr), 64'd0);
    check_eq("pay_idle.dest", 64'(dst_rr), 64'd0);
    check_eq("pay_idle.float", 64'(fl_rr), 64'd0);

    // Flush: pointer is held and aging state is cleared.
    do_reset();
    cyc("fl1", 4'b0010, 1'b0, 4'b0010, 4'b0010);
    cyc("fl2", 4'b1001, 1'b0, 4'b1000, 4'b0001);
    cyc("fl3", 4'b1001, 1'b0, 4'b0001, 4'b0001);
    @(negedge clk);
    req_valid = 4'b1001;
    flush     = 1'b1;
    #1;
    check_eq("flush.ack_rr", 64'(ack_rr), 64'd0);
    check_eq("flush.ack_fx", 64'(ack_fx), 64'd0);
    check_eq("flush.prior_valid_rr", 64'(v_rr), 64'd1);
    @(posedge clk);
    #1;
    check_eq("flush.valid_rr", 64'(v_rr), 64'd0);
    check_eq("flush.valid_fx", 64'(v_fx), 64'd0);
    check_eq("flush.src_rr", 64'(src_rr), 64'd0);
    cyc("fl5", 4'b1001, 1'b0, 4'b1000, 4'b0001);
    cyc("fl6", 4'b1001, 1'b0, 4'b0001, 4'b0001);
    cyc("fl7", 4'b1001, 1'b0, 4'b1000, 4'b0001);
    cyc("fl8", 4'b1001, 1'b0, 4'b0001, 4'b1000);

    // Asynchronous reset between clock edges while a broadcast is live.
    do_reset();
    cyc("ar", 4'b0010, 1'b0, 4'b0010, 4'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst.valid_rr", 64'(v_rr), 64'd0);
    check_eq("arst.value_rr", 64'(val_rr), 64'd0);
    check_eq("arst.src_rr", 64'(src_rr), 64'd0);
    check_eq("arst.valid_fx", 64'(v_fx), 64'd0);
    check_eq("arst.ack_rr", 64'(ack_rr), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc("post_ar", 4'b0010, 1'b0, 4'b0010, 4'b0010);

    req_valid = '0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
